gcm_seq_checker: RTL and testbench
==================================

Name: gcm_seq_checker

Overview:
- Receive-side companion to the machine-cycle phase generator. Monitors the five one-hot phase strobes A, E, B, C, D that drive the 4-bit microprocessor datapath.
- Reconstructs the current step number and locks onto the 7-step pattern A,E,B,E,C,D,D.
- Flags any deviation and counts faults, so the datapath and testbenches can trust, or reject, the phase stream.

Parameters:
- LOCK_CYCLES, 2: consecutive complete, error-free 7-step cycles required before asserting lock (range 1..15).
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_i  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
- A_i  input  1  phase strobe A (step 0).
- E_i  input  1  phase strobe E (steps 1 and 3).
- B_i  input  1  phase strobe B (step 2).
- C_i  input  1  phase strobe C (step 4).
- D_i  input  1  phase strobe D (steps 5 and 6).
- step_o  output  4  reconstructed step of the last accepted sample, 0..6.
- locked_o  output  1  high while in LOCKED.
- cycle_done_o  output  1  one-cycle pulse when LOCKED accepts A after step 6.
- err_o  output  1  one-cycle pulse on a mismatch while LOCKED.
- err_cnt_o  output  ERR_W  count of LOCKED mismatches; saturates at all-ones.

Behaviour:
- Phase code: {A,E,B,C,D} maps to codes 0,1,2,3,4.
  - The sample is valid only if exactly one strobe is high.
  - Zero or multiple strobes high: invalid, which never matches.
- Expected pattern by step: PAT[0..6] = A,E,B,E,C,D,D. Next expected code = PAT[(step+1) mod 7].
- All outputs are registered and update on the same edge that samples the strobes. Latency 1 clock from strobe to output.
- Reset (rst_i=0 at an edge): state=HUNT, step_o=0, locked_o=0, cycle_done_o=0, err_o=0, err_cnt_o=0, good-cycle counter=0.
  - Reset overrides all events, including mid-cycle.
- HUNT:
  - Valid A: step=0, good_cnt=0, go to TRACK.
  - Anything else: remain, no error.
- TRACK:
  - Match: step advances. If the new step is 0, good_cnt increments.
  - When good_cnt reaches LOCK_CYCLES: go to LOCKED, locked_o=1 on that same edge.
  - Mismatch: good_cnt=0, no err_o, no count.
    - If the sample is a valid A: step=0, stay in TRACK (resync).
    - Otherwise: go to HUNT, step_o holds its value.
- LOCKED:
  - Match: step advances. cycle_done_o=1 for the edge where step wraps 6→0.
  - Mismatch: err_o=1 for one cycle, err_cnt_o increments (saturating), locked_o=0 on that edge, good_cnt=0.
    - If the sample is a valid A: step=0, go to TRACK.
    - Otherwise: go to HUNT.
- Boundary cases:
  - A after step 5 (a short D phase) is a mismatch.
  - D repeated at step 6 (a third D) is a mismatch.
  - All-zero and multi-hot samples are mismatches in TRACK/LOCKED and ignored in HUNT.
  - err_cnt_o at all-ones stays there; err_o still pulses.
- Illegal/unused state encodings recover to HUNT on the next edge.

Decomposition:
- Shared package gcm_pkg:
  - Phase code constants PH_A, PH_E, PH_B, PH_C, PH_D.
  - Pattern constant PAT (7 entries).
  - STEP_LAST = 6.
  - State encodings HUNT, TRACK, LOCKED.
- Sub-module phase_onehot_dec: combinational; maps {A,E,B,C,D} to a 3-bit code plus a valid flag.
- The top holds the state machine, step register, good-cycle counter and error counter.

Test Plan:
- Reset, then a clean stream starting with A (A,E,B,E,C,D,D repeating):
  - TRACK from the first A.
  - With LOCK_CYCLES=2, locked_o rises on the edge sampling the third A, 14 clocks after the first.
  - step_o follows 0,1,2,3,4,5,6,0.
  - cycle_done_o pulses only on A samples once locked.
- While locked, replace the step-4 C with B:
  - err_o=1 for one clock, err_cnt_o 0→1, locked_o=0, state HUNT.
  - Relock 14 clocks after the next A.
- While locked, inject A after step 3:
  - err_o pulse, err_cnt_o increments, step_o=0, state TRACK (immediate resync), no intervening HUNT.
- Drive all-zero, then A+E together, during HUNT: no error and no state change. The same samples while locked give one err_o pulse each.
- ERR_W=2, force 5 locked mismatches: err_cnt_o reads 1,2,3,3,3; err_o pulses all 5 times.
- Assert rst_i=0 for one clock mid-cycle while locked at step 4:
  - Next edge gives all outputs 0 and state HUNT.
  - A clean stream relocks after the normal 14 clocks.

Source files
------------

// File: rtl/gcm_pkg.sv
// Shared definitions for the phase-sequence checker: phase codes, the
// expected 7-step strobe pattern and the checker state encoding.
package gcm_pkg;

  typedef logic [2:0] phase_code_t;

  localparam phase_code_t PH_A = 3'd0;
  localparam phase_code_t PH_E = 3'd1;
  localparam phase_code_t PH_B = 3'd2;
  localparam phase_code_t PH_C = 3'd3;
  localparam phase_code_t PH_D = 3'd4;

  localparam logic [2:0] STEP_LAST = 3'd6;

  // Machine-cycle order of the phase strobes, indexed by step number.
  localparam phase_code_t PAT [0:6] = '{PH_A, PH_E, PH_B, PH_E, PH_C, PH_D, PH_D};

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  // Step that follows 'step' in the 7-step cycle, wrapping 6 -> 0.
  function automatic logic [2:0] next_step(input logic [2:0] step);
    return (step >= STEP_LAST) ? 3'd0 : step + 3'd1;
  endfunction

endpackage

// File: rtl/gcm_seq_checker_if.sv
// Phase-strobe bundle plus the checker's status outputs. The phase
// generator (master) drives the strobes; the checker (slave) reports status.
interface gcm_seq_checker_if #(
  parameter int ERR_W = 8
);
  logic             A_i;
  logic             E_i;
  logic             B_i;
  logic             C_i;
  logic             D_i;
  logic [3:0]       step_o;
  logic             locked_o;
  logic             cycle_done_o;
  logic             err_o;
  logic [ERR_W-1:0] err_cnt_o;

  modport master (
    output A_i, E_i, B_i, C_i, D_i,
    input  step_o, locked_o, cycle_done_o, err_o, err_cnt_o
  );

  modport slave (
    input  A_i, E_i, B_i, C_i, D_i,
    output step_o, locked_o, cycle_done_o, err_o, err_cnt_o
  );
endinterface

// File: rtl/phase_onehot_dec.sv
// Turns the five phase strobes into a 3-bit phase code. Anything other
// than exactly one strobe high is reported as invalid.
module phase_onehot_dec
  import gcm_pkg::*;
(
  input  logic        a_i,
  input  logic        e_i,
  input  logic        b_i,
  input  logic        c_i,
  input  logic        d_i,
  output phase_code_t code_o,
  output logic        valid_o
);

  logic [4:0] strobes;

  assign strobes = {a_i, e_i, b_i, c_i, d_i};

  // One-hot decode; all-zero and multi-hot patterns fall to the invalid default.
  always_comb begin
    code_o  = PH_A;
    valid_o = 1'b0;
    case (strobes)
      5'b10000: begin code_o = PH_A; valid_o = 1'b1; end
      5'b01000: begin code_o = PH_E; valid_o = 1'b1; end
      5'b00100: begin code_o = PH_B; valid_o = 1'b1; end
      5'b00010: begin code_o = PH_C; valid_o = 1'b1; end
      5'b00001: begin code_o = PH_D; valid_o = 1'b1; end
      default:  begin code_o = PH_A; valid_o = 1'b0; end
    endcase
  end

endmodule

// File: rtl/gcm_seq_checker.sv
// Receive-side phase-sequence checker. Hunts for an A strobe, tracks the
// A,E,B,E,C,D,D pattern until LOCK_CYCLES clean cycles have been seen,
// then stays locked, flagging and counting every deviation.
module gcm_seq_checker
  import gcm_pkg::*;
#(
  parameter int LOCK_CYCLES = 2,
  parameter int ERR_W       = 8
) (
  input  logic              clk,
  input  logic              rst_i,
  gcm_seq_checker_if.slave  bus
);

  phase_code_t      code;
  logic             valid;
  logic [2:0]       step_nxt;
  logic             match;
  logic             is_a;
  logic [3:0]       good_inc;

  state_e           state_q, state_d;
  logic [2:0]       step_q, step_d;
  logic [3:0]       good_q, good_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             locked_q, locked_d;
  logic             cycle_done_q, cycle_done_d;
  logic             err_q, err_d;

  phase_onehot_dec u_dec (
    .a_i     (bus.A_i),
    .e_i     (bus.E_i),
    .b_i     (bus.B_i),
    .c_i     (bus.C_i),
    .d_i     (bus.D_i),
    .code_o  (code),
    .valid_o (valid)
  );

  assign step_nxt = next_step(step_q);
  assign match    = valid && (code == PAT[step_nxt]);
  assign is_a     = valid && (code == PH_A);
  assign good_inc = good_q + 4'd1;

  // Next-state, step, good-cycle and error-counter logic for the lock FSM.
  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    good_d       = good_q;
    err_cnt_d    = err_cnt_q;
    cycle_done_d = 1'b0;
    err_d        = 1'b0;
    case (state_q)
      HUNT: begin
        if (is_a) begin
          step_d  = 3'd0;
          good_d  = 4'd0;
          state_d = TRACK;
        end
      end
      TRACK: begin
        if (match) begin
          step_d = step_nxt;
          if (step_nxt == 3'd0) begin
            good_d = good_inc;
            if (good_inc == 4'(LOCK_CYCLES)) begin
              state_d = LOCKED;
            end
          end
        end else begin
          good_d = 4'd0;
          if (is_a) begin
            step_d = 3'd0;
          end else begin
            state_d = HUNT;
          end
        end
      end
      LOCKED: begin
        if (match) begin
          step_d       = step_nxt;
          cycle_done_d = (step_nxt == 3'd0);
        end else begin
          err_d     = 1'b1;
          err_cnt_d = (err_cnt_q == {ERR_W{1'b1}}) ? err_cnt_q : err_cnt_q + ERR_W'(1);
          good_d    = 4'd0;
          if (is_a) begin
            step_d  = 3'd0;
            state_d = TRACK;
          end else begin
            state_d = HUNT;
          end
        end
      end
      default: begin
        state_d = HUNT;
        good_d  = 4'd0;
      end
    endcase
    locked_d = (state_d == LOCKED);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_i) begin
      state_q      <= HUNT;
      step_q       <= 3'd0;
      good_q       <= 4'd0;
      err_cnt_q    <= '0;
      locked_q     <= 1'b0;
      cycle_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      good_q       <= good_d;
      err_cnt_q    <= err_cnt_d;
      locked_q     <= locked_d;
      cycle_done_q <= cycle_done_d;
      err_q        <= err_d;
    end
  end

  assign bus.step_o       = {1'b0, step_q};
  assign bus.locked_o     = locked_q;
  assign bus.cycle_done_o = cycle_done_q;
  assign bus.err_o        = err_q;
  assign bus.err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_gcm_seq_checker.sv
// Scoreboard bench for gcm_seq_checker. Two instances (ERR_W=8 and ERR_W=2)
// see the same strobe stream; a reference model predicts every output.
module tb_gcm_seq_checker;

  localparam int LOCK = 2;

  localparam int M_HUNT   = 0;
  localparam int M_TRACK  = 1;
  localparam int M_LOCKED = 2;

  typedef struct {
    int step;
    int locked;
    int cd;
    int err;
    int cnt8;
    int cnt2;
  } exp_t;

  logic clk;
  logic rst_i;

  gcm_seq_checker_if #(.ERR_W(8)) bus8 ();
  gcm_seq_checker_if #(.ERR_W(2)) bus2 ();

  gcm_seq_checker #(.LOCK_CYCLES(LOCK), .ERR_W(8)) dut8 (
    .clk   (clk),
    .rst_i (rst_i),
    .bus   (bus8.slave)
  );

  gcm_seq_checker #(.LOCK_CYCLES(LOCK), .ERR_W(2)) dut2 (
    .clk   (clk),
    .rst_i (rst_i),
    .bus   (bus2.slave)
  );

  // One-hot strobe words {A,E,B,C,D} and the phase code expected at each step.
  logic [4:0] pat_oh [0:6];
  int         pat_code [0:6];

  exp_t exp_q [$];
  int   tests_run;
  int   tests_failed;
  int   gen_pos;

  int m_state, m_step, m_good, m_cnt8, m_cnt2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one sample (strobes + reset) and push the predicted outputs.
  task automatic applyStimulus(input logic [4:0] s, input logic rst);
    exp_t e;
    int   code;
    int   nxt;
    bit   valid, match, is_a;
    rst_i     = rst;
    bus8.A_i  = s[4]; bus8.E_i = s[3]; bus8.B_i = s[2]; bus8.C_i = s[1]; bus8.D_i = s[0];
    bus2.A_i  = s[4]; bus2.E_i = s[3]; bus2.B_i = s[2]; bus2.C_i = s[1]; bus2.D_i = s[0];
    e.cd  = 0;
    e.err = 0;
    if (!rst) begin
      m_state = M_HUNT; m_step = 0; m_good = 0; m_cnt8 = 0; m_cnt2 = 0;
    end else begin
      valid = ($countones(s) == 1);
      code  = -1;
      if (valid) for (int k = 0; k < 5; k++) if (s[4-k]) code = k;
      nxt   = (m_step + 1) % 7;
      match = valid && (code == pat_code[nxt]);
      is_a  = valid && (code == 0);
      case (m_state)
        M_HUNT: if (is_a) begin m_step = 0; m_good = 0; m_state = M_TRACK; end
        M_TRACK: begin
          if (match) begin
            m_step = nxt;
            if (nxt == 0) begin
              m_good++;
              if (m_good == LOCK) m_state = M_LOCKED;
            end
          end else begin
            m_good = 0;
            if (is_a) m_step = 0;
            else m_state = M_HUNT;
          end
        end
        default: begin
          if (match) begin
            m_step = nxt;
            e.cd = (nxt == 0);
          end else begin
            e.err = 1;
            if (m_cnt8 < 255) m_cnt8++;
            if (m_cnt2 < 3) m_cnt2++;
            m_good = 0;
            if (is_a) begin m_step = 0; m_state = M_TRACK; end
            else m_state = M_HUNT;
          end
        end
      endcase
    end
    e.step   = m_step;
    e.locked = (m_state == M_LOCKED);
    e.cnt8   = m_cnt8;
    e.cnt2   = m_cnt2;
    exp_q.push_back(e);
  endtask

  task automatic cmp(input string name, input int act, input int req);
    tests_run++;
    if (act != req) begin
      tests_failed++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  // Compare every observable output of both instances against one prediction.
  task automatic checkOutput(input exp_t e);
    cmp("step_o",       int'(bus8.step_o),       e.step);
    cmp("locked_o",     int'(bus8.locked_o),     e.locked);
    cmp("cycle_done_o", int'(bus8.cycle_done_o), e.cd);
    cmp("err_o",        int'(bus8.err_o),        e.err);
    cmp("err_cnt_o",    int'(bus8.err_cnt_o),    e.cnt8);
    cmp("w2_err_o",     int'(bus2.err_o),        e.err);
    cmp("w2_err_cnt_o", int'(bus2.err_cnt_o),    e.cnt2);
    cmp("w2_locked_o",  int'(bus2.locked_o),     e.locked);
  endtask

  // Monitor: one registered result per clock, sampled just after the edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
  end

  task automatic sendSample(input logic [4:0] s, input logic rst);
    @(negedge clk);
    applyStimulus(s, rst);
  endtask

  task automatic sendClean(input int n);
    for (int i = 0; i < n; i++) begin
      sendSample(pat_oh[gen_pos], 1'b1);
      gen_pos = (gen_pos + 1) % 7;
    end
  endtask

  task automatic sendUntil(input int p);
    while (gen_pos != p) sendClean(1);
  endtask

  initial begin
    int r;
    logic [4:0] s;
    pat_oh   = '{5'b10000, 5'b01000, 5'b00100, 5'b01000, 5'b00010, 5'b00001, 5'b00001};
    pat_code = '{0, 1, 2, 1, 3, 4, 4};
    tests_run = 0; tests_failed = 0; gen_pos = 0;
    m_state = M_HUNT; m_step = 0; m_good = 0; m_cnt8 = 0; m_cnt2 = 0;

    applyStimulus(5'b00000, 1'b0);
    sendSample(5'b10000, 1'b0);

    // Clean stream: lock on the third A.
    sendClean(28);
    // Step-4 C replaced by B.
    sendUntil(4); sendSample(5'b00100, 1'b1); gen_pos = 0; sendClean(21);
    // Short D phase: A right after step 5.
    sendUntil(6); sendSample(5'b10000, 1'b1); gen_pos = 1; sendClean(21);
    // Third D after step 6.
    sendUntil(0); sendClean(7); sendSample(5'b00001, 1'b1); gen_pos = 0; sendClean(21);
    // A injected after step 3: immediate resync into TRACK.
    sendUntil(4); sendSample(5'b10000, 1'b1); gen_pos = 1; sendClean(21);
    // All-zero while locked, then junk ignored in HUNT.
    sendSample(5'b00000, 1'b1); sendSample(5'b00000, 1'b1);
    sendSample(5'b11000, 1'b1); sendSample(5'b00000, 1'b1);
    gen_pos = 0; sendClean(21);
    // Multi-hot while locked.
    sendSample(5'b11000, 1'b1); gen_pos = 0; sendClean(21);
    // Reset mid-cycle right after step 4 was accepted.
    sendUntil(5); sendSample(pat_oh[5], 1'b0); gen_pos = 0; sendClean(21);

    // Randomised stream: mostly clean, with corruption and occasional reset.
    for (int i = 0; i < 2000; i++) begin
      r = int'($urandom_range(0, 199));
      if (r == 0) begin
        sendSample(pat_oh[gen_pos], 1'b0);
      end else if (r < 12) begin
        s = 5'($urandom_range(0, 31));
        sendSample(s, 1'b1);
        if (s == 5'b10000) gen_pos = 1;
      end else begin
        sendClean(1);
      end
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL drain: %0d results pending, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
